// File: rtl/nic8_out_decimal.sv
// ---------------------------------------------------------------------------
// nic8_out_decimal
//
// Receiver for the nic8 CPU output port. Bytes written by the CPU's OUT
// instruction are captured into a small FIFO. Each byte is then converted to
// three zero-padded decimal ASCII digits and streamed over a valid/ready
// character interface to a console or UART transmitter.
//
// Build option:
//   NIC8_OUT_NEWLINE_EN  when defined, each value is followed by 0x0A
//                        (4 characters per byte); otherwise 3 characters.
//
// Parameters:
//   FIFO_DEPTH   input FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   out_strobe   CPU doOut strobe
//   out_data     CPU dbus value, sampled with out_strobe
//   fifo_full    FIFO holds FIFO_DEPTH entries
//   overflow     sticky, a strobe was dropped because the FIFO was full
//   char_valid   a character is presented on char_data
//   char_data    ASCII character (0x00 when not valid)
//   char_ready   sink accepts the presented character
//   busy         conversion/emission in progress or FIFO non-empty
// ---------------------------------------------------------------------------
module nic8_out_decimal #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       out_strobe,
    input  logic [7:0] out_data,
    output logic       fifo_full,
    output logic       overflow,
    output logic       char_valid,
    output logic [7:0] char_data,
    input  logic       char_ready,
    output logic       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HUND,
        TENS,
        EMIT_H,
        EMIT_T,
        EMIT_U
`ifdef NIC8_OUT_NEWLINE_EN
        , EMIT_NL
`endif
    } state_t;

    state_t state;
    state_t next_state;

    // -----------------------------------------------------------------------
    // Input FIFO
    // -----------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty     = (count == '0);
    assign fifo_full = (count == DEPTH_CNT);
    // Fullness is judged on the registered count, so a pop on the same edge
    // never rescues a strobe that arrives while full.
    assign push      = out_strobe && !fifo_full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    // NOTE: storage array has no reset; clearing the pointers and count is
    // what empties the FIFO, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (out_strobe && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Conversion datapath: repeated subtraction of 100 then 10
    // -----------------------------------------------------------------------
    logic [7:0] rem;
    logic [1:0] h;
    logic [3:0] t;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem <= '0;
            h   <= '0;
            t   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        rem <= mem[rd_ptr];
                        h   <= '0;
                        t   <= '0;
                    end
                end
                HUND: begin
                    if (rem >= 8'd100) begin
                        rem <= rem - 8'd100;
                        h   <= h + 2'd1;
                    end
                end
                TENS: begin
                    if (rem >= 8'd10) begin
                        rem <= rem - 8'd10;
                        t   <= t + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        char_valid = 1'b0;
        char_data  = 8'h00;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = HUND;
                end
            end
            HUND: begin
                if (rem < 8'd100) begin
                    next_state = TENS;
                end
            end
            TENS: begin
                if (rem < 8'd10) begin
                    next_state = EMIT_H;
                end
            end
            EMIT_H: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + {6'b0, h};
                if (char_ready) begin
                    next_state = EMIT_T;
                end
            end
            EMIT_T: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + {4'b0, t};
                if (char_ready) begin
                    next_state = EMIT_U;
                end
            end
            EMIT_U: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + rem;
                if (char_ready) begin
`ifdef NIC8_OUT_NEWLINE_EN
                    next_state = EMIT_NL;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef NIC8_OUT_NEWLINE_EN
            EMIT_NL: begin
                char_valid = 1'b1;
                char_data  = 8'h0A;
                if (char_ready) begin
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nic8_out_decimal.sv
// ---------------------------------------------------------------------------
// tb_nic8_out_decimal
//
// Scoreboard bench: stimulus pushes the expected decimal characters of each
// accepted byte into a queue; an independent monitor pops and compares on
// every character transfer and checks that a stalled character holds.
// ---------------------------------------------------------------------------
module tb_nic8_out_decimal;

    localparam int DEPTH = 4;
`ifdef NIC8_OUT_NEWLINE_EN
    localparam int CPB = 4;
`else
    localparam int CPB = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       out_strobe = 1'b0;
    logic [7:0] out_data = 8'h00;
    logic       char_ready = 1'b0;
    logic       fifo_full;
    logic       overflow;
    logic       char_valid;
    logic [7:0] char_data;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    nic8_out_decimal #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_strobe (out_strobe),
        .out_data   (out_data),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: decimal digits straight from integer division.
    function automatic void push_expected(input int v);
        exp_q.push_back(8'(48 + v / 100));
        exp_q.push_back(8'(48 + (v / 10) % 10));
        exp_q.push_back(8'(48 + v % 10));
`ifdef NIC8_OUT_NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
    endfunction

    // Monitor: samples 1 time unit after the falling edge, after the driver
    // has settled char_ready for the coming rising edge.
    initial begin
        logic       hold;
        logic [7:0] held;
        logic [7:0] e;
        hold = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("stall_valid_held", int'(char_valid), 1);
                check("stall_data_held", int'(char_data), int'(held));
            end
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got 0x%0h with empty scoreboard", char_data);
                end else begin
                    e = exp_q.pop_front();
                    check("char", int'(char_data), int'(e));
                end
                hold = 1'b0;
            end else if (char_valid) begin
                hold = 1'b1;
                held = char_data;
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        fail_timeout("wait_idle");
    endtask

    // Returns just before the rising edge that transfers the last character.
    task automatic wait_drained();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) return;
        end
        fail_timeout("wait_drained");
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (char_valid) return;
        end
        fail_timeout(name);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_char_valid"}, int'(char_valid), 0);
        check({tag, "_char_data"}, int'(char_data), 0);
        check({tag, "_fifo_full"}, int'(fifo_full), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic latency_test(input int v, input int exp_lat, input string name);
        int  n;
        bit  got;
        wait_idle();
        char_ready = 1'b1;
        out_strobe = 1'b1;
        out_data   = 8'(v);
        push_expected(v);
        @(posedge clk);            // edge 0: strobe sampled
        @(negedge clk);
        out_strobe = 1'b0;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (char_valid) got = 1'b1;
        end
        if (!got) fail_timeout(name);
        else      check(name, n, exp_lat);
        wait_drained();
        @(posedge clk);
        #1;
        check({name, "_busy_after_last"}, int'(busy), 0);
    endtask

    initial begin
        int v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n      = 1'b1;
        char_ready = 1'b1;

        // Latency: value 0 -> 3 cycles, value 255 -> 10 cycles
        latency_test(0, 3, "latency_0x00");
        latency_test(255, 10, "latency_0xFF");

        // Backpressure: first digit of 123 holds while char_ready is low
        wait_idle();
        char_ready = 1'b0;
        out_strobe = 1'b1;
        out_data   = 8'h7B;
        push_expected(8'h7B);
        @(negedge clk);
        out_strobe = 1'b0;
        wait_valid("hold_wait_valid");
        for (int k = 0; k < 5; k++) begin
            check("hold_0x7B_digit", int'(char_data), 8'h31);
            @(negedge clk);
        end
        char_ready = 1'b1;
        wait_idle();

        // Overflow: six strobes, sink stalled; byte 1 is popped at once,
        // bytes 2..5 fill the FIFO, byte 6 is dropped.
        char_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) check("full_after_4_strobes", int'(fifo_full), 0);
            if (i == 6) begin
                check("full_after_5_strobes", int'(fifo_full), 1);
                check("overflow_before_drop", int'(overflow), 0);
            end
            out_strobe = 1'b1;
            out_data   = 8'(i);
            if (i <= 5) push_expected(i);
        end
        @(negedge clk);
        out_strobe = 1'b0;
        check("overflow_after_drop", int'(overflow), 1);
        check("full_still_set", int'(fifo_full), 1);
        char_ready = 1'b1;
        wait_idle();
        check("overflow_sticky", int'(overflow), 1);

        // Reset mid-emission with entries queued
        char_ready = 1'b0;
        out_strobe = 1'b1;
        out_data   = 8'hC8;
        push_expected(8'hC8);
        @(negedge clk);
        out_data = 8'h11;
        push_expected(8'h11);
        @(negedge clk);
        out_data = 8'h22;
        push_expected(8'h22);
        @(negedge clk);
        out_strobe = 1'b0;
        wait_valid("reset_wait_valid");
        check("c8_hundreds", int'(char_data), 8'h32);
        char_ready = 1'b1;
        @(negedge clk);
        check("c8_tens_valid", int'(char_valid), 1);
        check("c8_tens", int'(char_data), 8'h30);
        char_ready = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_reset_values("midreset");
        @(negedge clk);
        rst_n      = 1'b1;
        char_ready = 1'b1;
        out_strobe = 1'b1;
        out_data   = 8'h09;
        push_expected(8'h09);
        @(negedge clk);
        out_strobe = 1'b0;
        wait_idle();

        // Back-to-back 10 and 20
        out_strobe = 1'b1;
        out_data   = 8'h0A;
        push_expected(8'h0A);
        @(negedge clk);
        out_data = 8'h14;
        push_expected(8'h14);
        @(negedge clk);
        out_strobe = 1'b0;
        wait_idle();

        // Random traffic; strobe only while outstanding bytes < DEPTH so the
        // FIFO cannot be full and every strobe must be accepted.
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            char_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && exp_q.size() <= (DEPTH - 1) * CPB) begin
                v          = int'($urandom_range(0, 255));
                out_strobe = 1'b1;
                out_data   = 8'(v);
                push_expected(v);
                check("rand_not_full", int'(fifo_full), 0);
            end else begin
                out_strobe = 1'b0;
            end
        end
        @(negedge clk);
        out_strobe = 1'b0;
        char_ready = 1'b1;
        wait_idle();
        check("rand_no_overflow", int'(overflow), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
